// File: rtl/field_cfg_rx_buffer.sv
// field_cfg_rx_buffer: assembles a FIELD_W*FIELD_H configuration image from a byte stream,
// kicks the loader and answers its coordinate scan. Optional feature macro: FIELD_CFG_RX_TIMEOUT_EN.
`default_nettype none

module field_cfg_rx_buffer #(
    parameter int FIELD_W     = 5,
    parameter int FIELD_H     = 3,
    parameter int TIMEOUT_CYC = 1000000,
    localparam int X_ADR_SIZE = $clog2(FIELD_W),
    localparam int Y_ADR_SIZE = $clog2(FIELD_H)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            i_byte,
    input  logic                  i_byte_valid,
    output logic                  o_byte_ready,
    output logic                  o_go,
    input  logic                  i_is_loading,
    input  logic [X_ADR_SIZE-1:0] i_cur_x,
    input  logic [Y_ADR_SIZE-1:0] i_cur_y,
    output logic                  o_cell_we,
    output logic [X_ADR_SIZE-1:0] o_cell_x,
    output logic [Y_ADR_SIZE-1:0] o_cell_y,
    output logic                  o_cell_val,
    output logic                  o_frame_done
`ifdef FIELD_CFG_RX_TIMEOUT_EN
    ,
    output logic                  o_timeout
`endif
);

    localparam int N_CELLS = FIELD_W * FIELD_H;
    localparam int N_BYTES = (N_CELLS + 7) / 8;
    localparam int IDX_W   = $clog2(N_CELLS) + 1;
    localparam int CNT_W   = $clog2(N_BYTES + 1);

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_GO      = 2'd1,
        S_WAIT    = 2'd2,
        S_STREAM  = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   byte_cnt;
    logic [N_CELLS-1:0] image;

    logic               xfer;
    logic               last_byte;
    logic               drop_frame;
    logic [IDX_W-1:0]   cell_idx;
    logic               cell_in_range;
    logic               cell_bit;

    assign xfer      = i_byte_valid && o_byte_ready;
    assign last_byte = (byte_cnt == CNT_W'(N_BYTES - 1));

`ifdef FIELD_CFG_RX_TIMEOUT_EN
    logic [31:0] idle_cnt;
    logic        idle_expired;

    assign idle_expired = (state == S_COLLECT) && (byte_cnt != '0) && !xfer
                          && (idle_cnt == 32'(TIMEOUT_CYC - 1));
    assign drop_frame   = idle_expired;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt  <= '0;
            o_timeout <= 1'b0;
        end else begin
            o_timeout <= idle_expired;
            if (state != S_COLLECT || byte_cnt == '0 || xfer || idle_expired) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + 32'd1;
            end
        end
    end
`else
    assign drop_frame = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    // Ready is gated by rst so every output reads 0 while reset is held.
    always_comb begin
        state_nxt    = state;
        o_byte_ready = 1'b0;
        o_go         = 1'b0;
        case (state)
            S_COLLECT: begin
                o_byte_ready = !rst;
                if (xfer && last_byte) begin
                    state_nxt = S_GO;
                end
            end
            S_GO: begin
                o_go      = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (i_is_loading) begin
                    state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                if (!i_is_loading) begin
                    state_nxt = S_COLLECT;
                end
            end
            default: state_nxt = S_COLLECT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt <= '0;
        end else if (drop_frame) begin
            byte_cnt <= '0;
        end else if (xfer) begin
            byte_cnt <= last_byte ? '0 : byte_cnt + CNT_W'(1);
        end
    end

    // Bits past N_CELLS in the final byte have no cell and are dropped here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            image <= '0;
        end else begin
            for (int i = 0; i < N_CELLS; i++) begin
                if (xfer && byte_cnt == CNT_W'(i / 8)) begin
                    image[i] <= i_byte[3'(i % 8)];
                end
            end
        end
    end

    assign cell_idx      = IDX_W'(i_cur_y) * IDX_W'(FIELD_W) + IDX_W'(i_cur_x);
    assign cell_in_range = (32'(i_cur_x) < 32'(FIELD_W)) && (32'(i_cur_y) < 32'(FIELD_H));

    always_comb begin
        cell_bit = 1'b0;
        for (int i = 0; i < N_CELLS; i++) begin
            if (cell_idx == IDX_W'(i)) begin
                cell_bit = image[i];
            end
        end
    end

    // The scan is answered from the WAIT cycle too so the loader's first cell is not lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_cell_we    <= 1'b0;
            o_cell_x     <= '0;
            o_cell_y     <= '0;
            o_cell_val   <= 1'b0;
            o_frame_done <= 1'b0;
        end else begin
            o_frame_done <= (state == S_STREAM) && !i_is_loading;
            if ((state == S_WAIT || state == S_STREAM) && i_is_loading && cell_in_range) begin
                o_cell_we  <= 1'b1;
                o_cell_x   <= i_cur_x;
                o_cell_y   <= i_cur_y;
                o_cell_val <= cell_bit;
            end else begin
                o_cell_we  <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire
